hs32_decode1_pipe: RTL and testbench

- Registered, parametrised first decode stage for the HS32 pipeline.
- Sits between fetch and execute and is driven by a valid/ready handshake.
- Decodes one 32-bit instruction per cycle, reads the rn operand, and scans NSTAGE downstream stages for hazards.
- Produces stall/bubble, a one-hot forward select, an undefined-opcode flag and a saturating stall counter, all from a skid-free output register.

---
 rtl/hs32_decode1_pipe.sv | 180 ++++++++++++++++++
 tb/tb_hs32_decode1_pipe.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs32_decode1_pipe.sv
// HS32 first decode stage: decodes one instruction per accept and scans downstream stages for hazards.
// One-cycle latency into a skid-free output register; ready_o drops on stall, flush or a blocked output.
module hs32_decode1_pipe #(
   parameter  int XLEN   = 32,
   parameter  int NSTAGE = 2,
   parameter  int CNTW   = 16,
   localparam int SHW    = $clog2(XLEN)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [31:0]           instr_i,
   input  logic                  flush_i,
   output logic [3:0]            rp_addr_o,
   input  logic [XLEN-1:0]       rp_data_i,
   input  logic [4*NSTAGE-1:0]   hz_rd_i,
   input  logic [NSTAGE-1:0]     hz_vld_i,
   input  logic [NSTAGE-1:0]     hz_late_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [3:0]            rd_o,
   output logic [3:0]            rm_o,
   output logic [XLEN-1:0]       d2_o,
   output logic [SHW-1:0]        shl_o,
   output logic [SHW-1:0]        shr_o,
   output logic                  sext_o,
   output logic                  maskl_o,
   output logic                  maskr_o,
   output logic [4:0]            opc_o,
   output logic [NSTAGE-1:0]     fwd_o,
   output logic                  ud_o,
   output logic [CNTW-1:0]       stall_cnt_o
);

   logic [5:0]  opcode;
   logic [3:0]  rd, rm, rn;
   logic [4:0]  sh;
   logic [1:0]  dir;
   logic [15:0] imm;
   logic        renc, ror;

   assign opcode = instr_i[31:26];
   assign rd     = instr_i[25:22];
   assign rm     = instr_i[21:18];
   assign rn     = instr_i[17:14];
   assign sh     = instr_i[13:9];
   assign dir    = instr_i[8:7];
   assign imm    = instr_i[15:0];
   assign renc   = opcode[4];
   assign ror    = &dir;

   assign rp_addr_o = rn;

   logic [NSTAGE-1:0] hit;
   logic [NSTAGE-1:0] fwd_d;
   logic              stall;
   logic              out_free;
   logic              accept;

   always_comb begin
      hit = '0;
      for (int k = 0; k < NSTAGE; k++) begin
         hit[k] = renc && hz_vld_i[k] && (hz_rd_i[4*k +: 4] == rn);
      end
   end

   assign stall = valid_i && (|(hit & hz_late_i));

   // Walk oldest to youngest so the youngest forwarding stage wins.
   always_comb begin
      fwd_d = '0;
      for (int k = NSTAGE - 1; k >= 0; k--) begin
         if (hit[k] && !hz_late_i[k]) begin
            fwd_d    = '0;
            fwd_d[k] = 1'b1;
         end
      end
   end

   assign out_free = !valid_o || ready_i;
   assign ready_o  = out_free && !stall && !flush_i;
   assign accept   = valid_i && ready_o;

   logic [31:0]     sh_m;
   logic [SHW-1:0]  shl_d, shr_d;
   logic [XLEN-1:0] d2_d;

   always_comb begin
      sh_m  = 32'(sh) % 32'(XLEN);
      shl_d = SHW'(sh_m);
      shr_d = ror ? SHW'((32'(XLEN) - sh_m) % 32'(XLEN)) : SHW'(sh_m);
      d2_d  = renc ? rp_data_i : {{(XLEN-16){imm[15]}}, imm};
   end

   function automatic logic ud_of(input logic [5:0] op);
      logic u;
      casez (op)
         6'b0?10??: u = 1'b0;
         6'b00000?: u = 1'b0;
         6'b1?0???: u = 1'b0;
         6'b1?1010: u = 1'b0;
         6'b1?1100: u = 1'b0;
         6'b010001: u = 1'b0;
         6'b010010: u = 1'b0;
         6'b010011: u = 1'b0;
         default:   u = 1'b1;
      endcase
      return u;
   endfunction

   logic              valid_q;
   logic [3:0]        rd_q, rm_q;
   logic [XLEN-1:0]   d2_q;
   logic [SHW-1:0]    shl_q, shr_q;
   logic              sext_q, maskl_q, maskr_q;
   logic [4:0]        opc_q;
   logic [NSTAGE-1:0] fwd_q;
   logic              ud_q;
   logic [CNTW-1:0]   cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         rd_q    <= '0;
         rm_q    <= '0;
         d2_q    <= '0;
         shl_q   <= '0;
         shr_q   <= '0;
         sext_q  <= 1'b0;
         maskl_q <= 1'b0;
         maskr_q <= 1'b0;
         opc_q   <= '0;
         fwd_q   <= '0;
         ud_q    <= 1'b0;
      end else begin
         if (flush_i) begin
            valid_q <= 1'b0;
         end else if (out_free) begin
            valid_q <= accept;
         end
         if (accept) begin
            rd_q    <= rd;
            rm_q    <= rm;
            d2_q    <= d2_d;
            shl_q   <= shl_d;
            shr_q   <= shr_d;
            sext_q  <= (dir == 2'b10);
            maskl_q <= !ror;
            maskr_q <= |dir;
            opc_q   <= {opcode[5], opcode[3:0]};
            fwd_q   <= fwd_d;
            ud_q    <= ud_of(opcode);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (stall && !flush_i && (cnt_q != {CNTW{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign valid_o     = valid_q;
   assign rd_o        = rd_q;
   assign rm_o        = rm_q;
   assign d2_o        = d2_q;
   assign shl_o       = shl_q;
   assign shr_o       = shr_q;
   assign sext_o      = sext_q;
   assign maskl_o     = maskl_q;
   assign maskr_o     = maskr_q;
   assign opc_o       = opc_q;
   assign fwd_o       = fwd_q;
   assign ud_o        = ud_q;
   assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_hs32_decode1_pipe.sv
// Bench for hs32_decode1_pipe: directed cases plus randomized traffic against a behavioural model.
module tb_hs32_decode1_pipe;
   localparam int NS = 2;

   logic          clk, rst_n, valid_i, flush_i, ready_i;
   logic [31:0]   instr, rp_data;
   logic [4*NS-1:0] hz_rd;
   logic [NS-1:0] hz_vld, hz_late;

   logic          ready_o, valid_o, sext_o, maskl_o, maskr_o, ud_o;
   logic [3:0]    rp_addr_o, rd_o, rm_o;
   logic [31:0]   d2_o;
   logic [4:0]    shl_o, shr_o, opc_o;
   logic [NS-1:0] fwd_o;
   logic [15:0]   cnt_o;

   logic          s_ready_o, s_valid_o, s_sext_o, s_maskl_o, s_maskr_o, s_ud_o;
   logic [3:0]    s_rp_addr_o, s_rd_o, s_rm_o;
   logic [31:0]   s_d2_o;
   logic [4:0]    s_shl_o, s_shr_o, s_opc_o;
   logic [NS-1:0] s_fwd_o;
   logic [3:0]    s_cnt_o;

   hs32_decode1_pipe #(.XLEN(32), .NSTAGE(NS), .CNTW(16)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o), .instr_i(instr),
      .flush_i(flush_i), .rp_addr_o(rp_addr_o), .rp_data_i(rp_data), .hz_rd_i(hz_rd),
      .hz_vld_i(hz_vld), .hz_late_i(hz_late), .valid_o(valid_o), .ready_i(ready_i),
      .rd_o(rd_o), .rm_o(rm_o), .d2_o(d2_o), .shl_o(shl_o), .shr_o(shr_o), .sext_o(sext_o),
      .maskl_o(maskl_o), .maskr_o(maskr_o), .opc_o(opc_o), .fwd_o(fwd_o), .ud_o(ud_o),
      .stall_cnt_o(cnt_o));

   hs32_decode1_pipe #(.XLEN(32), .NSTAGE(NS), .CNTW(4)) u_sat (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(s_ready_o), .instr_i(instr),
      .flush_i(flush_i), .rp_addr_o(s_rp_addr_o), .rp_data_i(rp_data), .hz_rd_i(hz_rd),
      .hz_vld_i(hz_vld), .hz_late_i(hz_late), .valid_o(s_valid_o), .ready_i(ready_i),
      .rd_o(s_rd_o), .rm_o(s_rm_o), .d2_o(s_d2_o), .shl_o(s_shl_o), .shr_o(s_shr_o),
      .sext_o(s_sext_o), .maskl_o(s_maskl_o), .maskr_o(s_maskr_o), .opc_o(s_opc_o),
      .fwd_o(s_fwd_o), .ud_o(s_ud_o), .stall_cnt_o(s_cnt_o));

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   int n_cmp = 0;
   int n_bad = 0;

   logic          m_valid, m_sext, m_maskl, m_maskr, m_ud;
   logic [3:0]    m_rd, m_rm;
   logic [31:0]   m_d2;
   int            m_shl, m_shr;
   logic [4:0]    m_opc;
   logic [NS-1:0] m_fwd;
   int            m_cnt, m_cnt4;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [3:0] rdv,
                                        input logic [3:0] rmv, input logic [3:0] rnv,
                                        input logic [4:0] shv, input logic [1:0] dirv);
      return {op, rdv, rmv, rnv, shv, dirv, 7'd0};
   endfunction

   function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [15:0] iv);
      return {op, 10'd0, iv};
   endfunction

   // Legal opcode map written as boolean rules on the bit fields.
   function automatic logic model_ud(input logic [5:0] o);
      logic legal;
      legal = (o[5] == 1'b0 && o[3:2] == 2'b10)
           || (o[5:1] == 5'd0)
           || (o[5] == 1'b1 && o[3] == 1'b0)
           || (o[5] == 1'b1 && o[3:0] == 4'hA)
           || (o[5] == 1'b1 && o[3:0] == 4'hC)
           || (o[5:2] == 4'b0100 && o[1:0] != 2'b00);
      return !legal;
   endfunction

   task automatic model_reset();
      m_valid = 0; m_rd = 0; m_rm = 0; m_d2 = 0; m_shl = 0; m_shr = 0;
      m_sext = 0; m_maskl = 0; m_maskr = 0; m_opc = 0; m_fwd = 0; m_ud = 0;
      m_cnt = 0; m_cnt4 = 0;
   endtask

   task automatic hz_eval(output logic st, output logic [NS-1:0] fw);
      logic any_late, found, h;
      any_late = 0; found = 0; fw = '0;
      for (int k = 0; k < NS; k++) begin
         h = instr[30] && hz_vld[k] && (hz_rd[4*k +: 4] == instr[17:14]);
         if (h && hz_late[k]) any_late = 1;
         if (h && !hz_late[k] && !found) begin
            fw[k] = 1'b1;
            found = 1;
         end
      end
      st = valid_i && any_late;
   endtask

   // One cycle: compare at the falling edge, advance the model, return just after the rising edge.
   task automatic step();
      logic st, exp_rdy, acc, ror;
      logic [NS-1:0] fw;
      int sh;
      @(negedge clk);
      hz_eval(st, fw);
      exp_rdy = (!m_valid || ready_i) && !st && !flush_i;
      chk("ready_o", 32'(ready_o), 32'(exp_rdy));
      chk("rp_addr_o", 32'(rp_addr_o), 32'(instr[17:14]));
      chk("valid_o", 32'(valid_o), 32'(m_valid));
      chk("rd_o", 32'(rd_o), 32'(m_rd));
      chk("rm_o", 32'(rm_o), 32'(m_rm));
      chk("d2_o", d2_o, m_d2);
      chk("shl_o", 32'(shl_o), 32'(m_shl));
      chk("shr_o", 32'(shr_o), 32'(m_shr));
      chk("sext_o", 32'(sext_o), 32'(m_sext));
      chk("maskl_o", 32'(maskl_o), 32'(m_maskl));
      chk("maskr_o", 32'(maskr_o), 32'(m_maskr));
      chk("opc_o", 32'(opc_o), 32'(m_opc));
      chk("fwd_o", 32'(fwd_o), 32'(m_fwd));
      chk("ud_o", 32'(ud_o), 32'(m_ud));
      chk("stall_cnt16", 32'(cnt_o), 32'(m_cnt));
      chk("stall_cnt4", 32'(s_cnt_o), 32'(m_cnt4));
      acc = valid_i && exp_rdy;
      if (st && !flush_i) begin
         if (m_cnt < 65535) m_cnt = m_cnt + 1;
         if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
      end
      if (flush_i) m_valid = 0;
      else if (!m_valid || ready_i) m_valid = acc;
      if (acc) begin
         sh      = int'(instr[13:9]);
         ror     = (instr[8:7] == 2'b11);
         m_rd    = instr[25:22];
         m_rm    = instr[21:18];
         m_d2    = instr[30] ? rp_data
                 : (instr[15] ? 32'(instr[15:0]) - 32'h10000 : 32'(instr[15:0]));
         m_shl   = sh % 32;
         m_shr   = ror ? (32 - sh) % 32 : sh % 32;
         m_sext  = (instr[8:7] == 2'b10);
         m_maskl = !ror;
         m_maskr = (instr[8:7] != 2'b00);
         m_opc   = {instr[31], instr[29:26]};
         m_fwd   = fw;
         m_ud    = model_ud(instr[31:26]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_inputs();
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 9) < 7);
      flush_i = ($urandom_range(0, 15) == 0);
      instr   = $urandom;
      instr[17:14] = 4'($urandom_range(0, 3));
      rp_data = $urandom;
      hz_rd   = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      hz_vld  = 2'($urandom);
      hz_late = 2'($urandom);
   endtask

   initial begin
      model_reset();
      rst_n = 0; valid_i = 0; flush_i = 0; ready_i = 1;
      instr = 0; rp_data = 0; hz_rd = 0; hz_vld = 0; hz_late = 0;
      #25 rst_n = 1;
      @(posedge clk); #1;
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_cnt", 32'(cnt_o), 32'd0);
      chk("rst_ready", 32'(ready_o), 32'd1);

      valid_i = 1; instr = mk_i(6'b000001, 16'h8001);
      step();
      chk("itype_valid", 32'(valid_o), 32'd1);
      chk("itype_d2", d2_o, 32'hFFFF8001);
      chk("itype_fwd", 32'(fwd_o), 32'd0);
      chk("itype_ud", 32'(ud_o), 32'd0);

      instr = mk_r(6'b010001, 4'd1, 4'd2, 4'd3, 5'd0, 2'b00); rp_data = 32'h12345678;
      step();
      chk("rtype_d2", d2_o, 32'h12345678);

      instr = mk_r(6'b100000, 4'd0, 4'd0, 4'd0, 5'd5, 2'b11);
      step();
      chk("ror_shr", 32'(shr_o), 32'd27);
      chk("ror_shl", 32'(shl_o), 32'd5);
      chk("ror_maskl", 32'(maskl_o), 32'd0);
      chk("ror_maskr", 32'(maskr_o), 32'd1);
      instr = mk_r(6'b100000, 4'd0, 4'd0, 4'd0, 5'd7, 2'b10);
      step();
      chk("sext", 32'(sext_o), 32'd1);
      instr = mk_r(6'b100000, 4'd0, 4'd0, 4'd0, 5'd0, 2'b11);
      step();
      chk("ror_sh0", 32'(shr_o), 32'd0);

      instr = mk_r(6'b010001, 4'd1, 4'd2, 4'd3, 5'd0, 2'b00);
      hz_rd = {4'd0, 4'd3}; hz_vld = 2'b01; hz_late = 2'b01;
      #1 chk("hz_late_ready", 32'(ready_o), 32'd0);
      step();
      chk("hz_bubble", 32'(valid_o), 32'd0);
      chk("hz_cnt", 32'(cnt_o), 32'd1);
      hz_late = 2'b00;
      step();
      chk("fwd_s0", 32'(fwd_o), 32'b01);
      hz_rd = {4'd3, 4'd5}; hz_vld = 2'b11;
      step();
      chk("fwd_s1", 32'(fwd_o), 32'b10);
      hz_rd = {4'd3, 4'd3};
      step();
      chk("fwd_shadow", 32'(fwd_o), 32'b01);

      hz_vld = 0; instr = mk_i(6'b000000, 16'h1234);
      step();
      ready_i = 0; instr = mk_i(6'b000000, 16'h4321);
      for (int i = 0; i < 3; i++) begin
         #1 chk("bp_ready", 32'(ready_o), 32'd0);
         step();
         chk("bp_valid", 32'(valid_o), 32'd1);
         chk("bp_d2", d2_o, 32'h00001234);
      end
      flush_i = 1;
      step();
      chk("flush_valid", 32'(valid_o), 32'd0);
      flush_i = 0; ready_i = 1;

      instr = mk_r(6'b010001, 4'd1, 4'd2, 4'd3, 5'd0, 2'b00);
      hz_rd = {4'd0, 4'd3}; hz_vld = 2'b01; hz_late = 2'b01;
      for (int i = 0; i < 20; i++) step();
      chk("sat_cnt4", 32'(s_cnt_o), 32'hF);
      chk("cnt16_21", 32'(cnt_o), 32'd21);
      hz_vld = 0; hz_late = 0;

      for (int op = 0; op < 64; op++) begin
         instr = {6'(op), 26'($urandom)};
         step();
         if (op == 6'b010000) chk("ud_010000", 32'(ud_o), 32'd1);
         if (op == 6'b010001) chk("ud_010001", 32'(ud_o), 32'd0);
         if (op == 6'b111011) chk("ud_111011", 32'(ud_o), 32'd1);
      end

      for (int i = 0; i < 3000; i++) begin
         randomize_inputs();
         step();
      end

      valid_i = 1; ready_i = 1; flush_i = 0; hz_vld = 0; instr = mk_i(6'b000001, 16'h7777);
      step();
      #3 rst_n = 0;
      #1;
      chk("arst_valid", 32'(valid_o), 32'd0);
      chk("arst_d2", d2_o, 32'd0);
      chk("arst_rd", 32'(rd_o), 32'd0);
      chk("arst_opc", 32'(opc_o), 32'd0);
      chk("arst_cnt16", 32'(cnt_o), 32'd0);
      chk("arst_cnt4", 32'(s_cnt_o), 32'd0);
      model_reset();
      #2 rst_n = 1;
      valid_i = 0;
      #1 chk("arst_ready", 32'(ready_o), 32'd1);
      for (int i = 0; i < 200; i++) begin
         randomize_inputs();
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
